// File: rtl/uart_pkg.sv
// Shared UART constants for the receive-side FIFO.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int FIFO_DEPTH_DEFAULT = 16;
  localparam int FIFO_AF_DEFAULT    = 12;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset on contents.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  // Write the incoming byte on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: edge-detected push, FWFT read, sticky overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = FIFO_DEPTH_DEFAULT,
  parameter int AF_THRESH = FIFO_AF_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [UART_DATA_W-1:0]     din,
  input  logic                       rx_done,
  input  logic                       rd_en,
  input  logic                       clr_overrun,
  output logic [UART_DATA_W-1:0]     dout,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic                   rx_done_q;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [UART_DATA_W-1:0] head;
  logic                   push;
  logic                   pop;
  logic                   push_ok;
  logic                   overrun_evt;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push        = rx_done & ~rx_done_q;
  assign pop         = rd_en & ~empty;
  assign push_ok     = push & (~full | pop);
  assign overrun_evt = push & full & ~pop;

  assign empty       = (level == '0);
  assign full        = (level == LW'(DEPTH));
  assign almost_full = (level >= LW'(AF_THRESH));
  assign dout        = empty ? '0 : head;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // rx_done_q resets high so a level held across reset release is not a new byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_done_q <= 1'b1;
    else        rx_done_q <= rx_done;
  end

  // Pointers wrap naturally at DEPTH; level tracks net push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      level <= level + LW'(1);
      else if (pop && !push_ok) level <= level - LW'(1);
    end
  end

  // Sticky overrun; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           overrun <= 1'b0;
    else if (overrun_evt) overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

endmodule : uart_rx_fifo
